// File: rtl/nn_sweep_pkg.sv
// nn_sweep_pkg: shared types and sizes for the exhaustive 4-input sweep controller.
//   state_t      : controller FSM states
//   NUM_VECTORS  : number of input vectors swept (all 4-bit combinations)
//   IDX_W        : width of the vector index
//   CNT_W        : width of the settle counter
package nn_sweep_pkg;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : nn_sweep_pkg

// File: rtl/nn_settle_timer.sv
// nn_settle_timer: settle-time countdown for one applied vector.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   load    : restart the countdown at SETTLE_CYCLES (issued as a vector is applied)
//   expired : registered, high during the last cycle of the settle window
module nn_settle_timer
  import nn_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_expired;

  // Count down from SETTLE_CYCLES, saturating at zero.
  always_comb begin
    w_cnt_n = r_cnt;
    if (load) begin
      w_cnt_n = CNT_W'(SETTLE_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_n = r_cnt - CNT_W'(1);
    end
  end

  // The window covers counts SETTLE_CYCLES..1, so flag the cycle holding count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_expired <= (w_cnt_n == CNT_W'(1));
    end
  end

  assign expired = r_expired;

endmodule : nn_settle_timer

// File: rtl/nn_sweep_ctrl.sv
// nn_sweep_ctrl: drives all 16 vectors into a 4-input combinational DUT, captures
// its output per vector and compares against a golden truth table.
//   clk, rst            : clock and synchronous active-high reset
//   start               : sweep request, honoured only in IDLE
//   abort               : cancel a running sweep (wins over start)
//   expected[15:0]      : golden truth table, bit i = expected w for vector i
//   w                   : DUT output
//   a, b, c, d          : DUT inputs, a = index bit 3 ... d = index bit 0
//   busy                : high while vectors are being applied/sampled
//   done                : one-cycle pulse after a completed sweep
//   truth_table[15:0]   : captured w values, bit i = vector i
//   mismatch            : sticky, set on first captured/expected difference
//   fail_index[3:0]     : index of the first mismatching vector
module nn_sweep_ctrl
  import nn_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        w,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        mismatch,
  output logic [3:0]  fail_index
);

  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("nn_sweep_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t                 r_state;
  state_t                 w_state_n;
  logic [IDX_W-1:0]       r_index;
  logic [IDX_W-1:0]       w_index_n;
  logic [NUM_VECTORS-1:0] r_expected_q;
  logic [NUM_VECTORS-1:0] r_truth;
  logic                   r_mismatch;
  logic [IDX_W-1:0]       r_fail_index;
  logic [IDX_W-1:0]       r_vec;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_load;
  logic                   w_expired;

  nn_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .expired (w_expired)
  );

  // Next-state, index advance and per-cycle strobes.
  always_comb begin
    w_state_n = r_state;
    w_index_n = r_index;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_n = SETTLE;
          w_index_n = '0;
          w_accept  = 1'b1;
          w_load    = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (w_expired) begin
          w_state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          w_state_n = IDLE;
        end else begin
          w_capture = 1'b1;
          if (r_index == LAST_IDX) begin
            w_state_n = DONE;
          end else begin
            w_state_n = SETTLE;
            w_index_n = r_index + IDX_W'(1);
            w_load    = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // State, capture/compare and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_expected_q <= '0;
      r_truth      <= '0;
      r_mismatch   <= 1'b0;
      r_fail_index <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_index <= w_index_n;

      if (w_accept) begin
        r_expected_q <= expected;
        r_truth      <= '0;
        r_mismatch   <= 1'b0;
        r_fail_index <= '0;
      end

      if (w_capture) begin
        r_truth[r_index] <= w;
        if ((w != r_expected_q[r_index]) && !r_mismatch) begin
          r_mismatch   <= 1'b1;
          r_fail_index <= r_index;
        end
      end

      // Vector and busy follow the state being entered so they line up with it.
      r_busy <= (w_state_n == SETTLE) || (w_state_n == SAMPLE);
      r_vec  <= ((w_state_n == SETTLE) || (w_state_n == SAMPLE)) ? w_index_n : '0;

      // done is the registered image of DONE, dropped if the sweep is aborted there.
      r_done <= (r_state == DONE) && !abort;
    end
  end

  assign a           = r_vec[3];
  assign b           = r_vec[2];
  assign c           = r_vec[1];
  assign d           = r_vec[0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_truth;
  assign mismatch    = r_mismatch;
  assign fail_index  = r_fail_index;

endmodule : nn_sweep_ctrl

// File: tb/tb_nn_sweep_ctrl.sv
// tb_nn_sweep_ctrl: self-checking bench, one instance at SETTLE_CYCLES=8 and one at 1.
module tb_nn_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, abort8, w8, a8, b8, c8, d8, busy8, done8, mm8;
  logic [15:0] exp8, tt8, func8;
  logic [3:0]  fi8;
  logic        rst1, start1, abort1, w1, a1, b1, c1, d1, busy1, done1, mm1;
  logic [15:0] exp1, tt1, func1;
  logic [3:0]  fi1;

  // Stub DUTs: truth-table lookups addressed by {a,b,c,d}.
  assign w8 = func8[{a8, b8, c8, d8}];
  assign w1 = func1[{a1, b1, c1, d1}];

  nn_sweep_ctrl #(.SETTLE_CYCLES(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .abort(abort8), .expected(exp8), .w(w8),
    .a(a8), .b(b8), .c(c8), .d(d8), .busy(busy8), .done(done8),
    .truth_table(tt8), .mismatch(mm8), .fail_index(fi8)
  );

  nn_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .expected(exp1), .w(w1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .truth_table(tt1), .mismatch(mm1), .fail_index(fi1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] func;
    logic [15:0] expected;
    logic [15:0] tt;
    logic        mm;
    logic [3:0]  fi;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth table of the complex gate w = ~((a&b)|(c&d)).
  function automatic logic [15:0] gate_tt();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      t[i] = ~((v[3] & v[2]) | (v[1] & v[0]));
    end
    return t;
  endfunction

  // Reference: captured table is the stub function; first differing bit is the fail index.
  function automatic void model(input logic [15:0] f, input logic [15:0] e,
                                output logic [15:0] tt, output logic mm, output logic [3:0] fi);
    tt = f;
    mm = 1'b0;
    fi = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (!mm && (f[i] != e[i])) begin
        mm = 1'b1;
        fi = 4'(i);
      end
    end
  endfunction

  // Run one sweep on dut8; lat = cycles from the start edge to done (-1 if none).
  task automatic sweep8(input logic [15:0] f, input logic [15:0] e, input int second_start_at,
                        output int lat);
    func8 = f;
    exp8  = e;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      if (n == second_start_at) start8 = 1'b1;
      tick();
      start8 = 1'b0;
      if (done8) lat = n;
    end
  endtask

  task automatic count_done8(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (done8) cnt++;
    end
  endtask

  // Start a sweep and stop at the first cycle that shows vector v; found=0 on timeout.
  task automatic run_to_vec8(input logic [3:0] v, output logic found);
    func8 = gate_tt();
    exp8  = 16'h0777;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if ({a8, b8, c8, d8} == v && busy8) found = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic        found;
    logic [15:0] f, e, m_tt;
    logic        m_mm;
    logic [3:0]  m_fi;

    rst8 = 1'b1; start8 = 1'b0; abort8 = 1'b0; exp8 = '0; func8 = '0;
    rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; exp1 = '0; func1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst1 = 1'b0;

    chk("reset_abcd", 32'({a8, b8, c8, d8}), 32'h0);
    chk("reset_busy", 32'(busy8), 32'h0);
    chk("reset_done", 32'(done8), 32'h0);
    chk("reset_tt",   32'(tt8), 32'h0);
    chk("reset_mm",   32'(mm8), 32'h0);
    chk("reset_fi",   32'(fi8), 32'h0);

    vecs[0] = '{gate_tt(),  16'h0777, 16'h0777, 1'b0, 4'h0};
    vecs[1] = '{gate_tt(),  16'h0F77, 16'h0777, 1'b1, 4'hB};
    vecs[2] = '{16'hFFFF,   16'h0000, 16'hFFFF, 1'b1, 4'h0};
    vecs[3] = '{16'h0000,   16'h8000, 16'h0000, 1'b1, 4'hF};
    vecs[4] = '{16'hA5A5,   16'hA5A5, 16'hA5A5, 1'b0, 4'h0};

    for (int i = 0; i < 5; i++) begin
      sweep8(vecs[i].func, vecs[i].expected, 0, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd145);
      chk($sformatf("vec%0d_tt", i), 32'(tt8), 32'(vecs[i].tt));
      chk($sformatf("vec%0d_mm", i), 32'(mm8), 32'(vecs[i].mm));
      chk($sformatf("vec%0d_fi", i), 32'(fi8), 32'(vecs[i].fi));
      chk($sformatf("vec%0d_busy_at_done", i), 32'(busy8), 32'h0);
      tick();
      chk($sformatf("vec%0d_done_one_cycle", i), 32'(done8), 32'h0);
    end

    repeat (10) tick();
    chk("hold_tt", 32'(tt8), 32'(vecs[4].tt));
    chk("hold_mm", 32'(mm8), 32'(vecs[4].mm));

    for (int r = 0; r < 6; r++) begin
      f = 16'($urandom);
      if (r % 3 == 0) e = f;
      else if (r % 3 == 1) e = f ^ (16'h0001 << $urandom_range(15, 0));
      else e = 16'($urandom);
      model(f, e, m_tt, m_mm, m_fi);
      sweep8(f, e, 0, lat);
      chk($sformatf("rand%0d_latency", r), 32'(lat), 32'd145);
      chk($sformatf("rand%0d_tt", r), 32'(tt8), 32'(m_tt));
      chk($sformatf("rand%0d_mm", r), 32'(mm8), 32'(m_mm));
      chk($sformatf("rand%0d_fi", r), 32'(fi8), 32'(m_fi));
    end

    // start and abort together in IDLE: abort wins, previous results untouched.
    start8 = 1'b1;
    abort8 = 1'b1;
    tick();
    start8 = 1'b0;
    abort8 = 1'b0;
    chk("prio_busy", 32'(busy8), 32'h0);
    tick();
    chk("prio_busy_later", 32'(busy8), 32'h0);
    chk("prio_tt_kept", 32'(tt8), 32'(m_tt));

    // Second start in mid-sweep is ignored.
    sweep8(gate_tt(), 16'h0777, 50, lat);
    chk("busy_start_latency", 32'(lat), 32'd145);
    chk("busy_start_tt", 32'(tt8), 32'h0777);
    count_done8(200, cnt);
    chk("busy_start_one_done", 32'(cnt), 32'h0);

    // Abort while settling vector 5.
    run_to_vec8(4'd5, found);
    chk("abort_reach_v5", 32'(found), 32'h1);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'h0);
    chk("abort_abcd", 32'({a8, b8, c8, d8}), 32'h0);
    chk("abort_done", 32'(done8), 32'h0);
    chk("abort_tt_hi", 32'(tt8[15:5]), 32'h0);
    f = gate_tt();
    chk("abort_tt_lo", 32'(tt8[4:0]), 32'(f[4:0]));
    count_done8(200, cnt);
    chk("abort_no_done", 32'(cnt), 32'h0);

    // Reset at vector 9, then a normal sweep.
    run_to_vec8(4'd9, found);
    chk("rst_reach_v9", 32'(found), 32'h1);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("rst_mid_abcd", 32'({a8, b8, c8, d8}), 32'h0);
    chk("rst_mid_busy", 32'(busy8), 32'h0);
    chk("rst_mid_done", 32'(done8), 32'h0);
    chk("rst_mid_tt",   32'(tt8), 32'h0);
    chk("rst_mid_mm",   32'(mm8), 32'h0);
    chk("rst_mid_fi",   32'(fi8), 32'h0);
    sweep8(gate_tt(), 16'h0F77, 0, lat);
    chk("after_rst_latency", 32'(lat), 32'd145);
    chk("after_rst_tt", 32'(tt8), 32'h0777);
    chk("after_rst_mm", 32'(mm8), 32'h1);
    chk("after_rst_fi", 32'(fi8), 32'hB);

    // Minimum settle: each vector held two cycles, done 33 cycles after start.
    func1 = gate_tt();
    exp1  = 16'h0777;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = -1;
    for (int n = 0; n <= 100 && lat < 0; n++) begin
      if (n < 32) chk($sformatf("min_hold_%0d", n), 32'({a1, b1, c1, d1}), 32'(n / 2));
      if (done1) lat = n;
      else tick();
    end
    chk("min_latency", 32'(lat), 32'd33);
    chk("min_tt", 32'(tt1), 32'h0777);
    chk("min_mm", 32'(mm1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nn_sweep_ctrl
